// File: rtl/tdc_hit_readout_if.sv
// Measurement word stream from the TDC hit readout toward the acquisition logic.
// The readout drives word and valid; the consumer answers with ready.
interface tdc_hit_readout_if #(
   parameter int DW = 17
) ();
   logic [DW-1:0] DATA_OUT;
   logic          DATA_VALID;
   logic          DATA_READY;

   modport master (output DATA_OUT, output DATA_VALID, input DATA_READY);
   modport slave  (input DATA_OUT, input DATA_VALID, output DATA_READY);
endinterface

// File: rtl/tdc_hit_readout.sv
// Measures each CountOn window as a coarse cycle count plus start/stop fine codes,
// buffers the packed words in a small FIFO and drains them over valid/ready.
module tdc_hit_readout #(
   parameter  int COARSE_W   = 8,
   parameter  int FIFO_DEPTH = 8,
   localparam int DW         = COARSE_W + 9
) (
   input  logic                CLK,
   input  logic                RSTn,
   input  logic                ENABLE,
   input  logic                CountOn,
   input  logic [3:0]          Z,
   tdc_hit_readout_if.master   bus,
   output logic                FIFO_FULL,
   output logic [7:0]          DROP_CNT,
   output logic                BUSY
);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic {IDLE, RUN} state_t;

   state_t              state, nextState;
   logic                countOnD, lowSeen;
   logic                rise, fall;
   logic                startMeas, countStep, endMeas;
   logic [COARSE_W-1:0] coarse;
   logic                ovf;
   logic [3:0]          zStart;
   logic                pushValid;
   logic [DW-1:0]       pushWord;
   logic [AW:0]         wrPtr, rdPtr, wrNext, rdNext;
   logic                pop, doPush;
   logic [DW-1:0]       headNext;
   logic [DW-1:0]       mem [FIFO_DEPTH];

   // lowSeen blocks a window that was already high when reset released
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         countOnD <= 1'b0;
         lowSeen  <= 1'b0;
      end else begin
         countOnD <= CountOn;
         lowSeen  <= lowSeen | ~CountOn;
      end
   end

   assign rise = CountOn & ~countOnD & lowSeen;
   assign fall = ~CountOn & countOnD;

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) state <= IDLE;
      else       state <= nextState;
   end

   always_comb begin
      nextState = state;
      startMeas = 1'b0;
      countStep = 1'b0;
      endMeas   = 1'b0;
      case (state)
         IDLE: begin
            if (rise && ENABLE) begin
               startMeas = 1'b1;
               nextState = RUN;
            end
         end
         RUN: begin
            if (fall) begin
               endMeas   = 1'b1;
               nextState = IDLE;
            end else if (CountOn) begin
               countStep = 1'b1;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   assign BUSY = (state == RUN);

   // The rise cycle itself counts as one, so COARSE equals the high-cycle count
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         coarse    <= '0;
         ovf       <= 1'b0;
         zStart    <= '0;
         pushValid <= 1'b0;
         pushWord  <= '0;
      end else begin
         pushValid <= endMeas;
         if (endMeas) pushWord <= {ovf, coarse, zStart, Z};
         if (startMeas) begin
            coarse <= COARSE_W'(1);
            ovf    <= 1'b0;
            zStart <= Z;
         end else if (countStep) begin
            if (&coarse) ovf    <= 1'b1;
            else         coarse <= coarse + COARSE_W'(1);
         end
      end
   end

   assign FIFO_FULL = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
   assign pop       = bus.DATA_VALID & bus.DATA_READY;
   assign doPush    = pushValid & (~FIFO_FULL | pop);
   assign wrNext    = wrPtr + (AW+1)'(doPush);
   assign rdNext    = rdPtr + (AW+1)'(pop);

   always_ff @(posedge CLK) begin
      if (doPush) mem[wrPtr[AW-1:0]] <= pushWord;
   end

   // Output register mirrors the next head; a word landing in an empty slot bypasses memory
   always_comb begin
      headNext = mem[rdNext[AW-1:0]];
      if (rdNext == wrPtr) headNext = pushWord;
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         wrPtr          <= '0;
         rdPtr          <= '0;
         bus.DATA_VALID <= 1'b0;
         bus.DATA_OUT   <= '0;
         DROP_CNT       <= '0;
      end else begin
         wrPtr          <= wrNext;
         rdPtr          <= rdNext;
         bus.DATA_VALID <= (wrNext != rdNext);
         if (wrNext != rdNext) bus.DATA_OUT <= headNext;
         if (pushValid && !doPush && DROP_CNT != 8'hFF) DROP_CNT <= DROP_CNT + 8'd1;
      end
   end
endmodule

// File: tb/tb_tdc_hit_readout.sv
// Randomised scoreboard bench for tdc_hit_readout: pulses are issued with a
// reference word queued per window; a negedge monitor compares every accepted word.
module tb_tdc_hit_readout;
   localparam int COARSE_W   = 8;
   localparam int FIFO_DEPTH = 8;
   localparam int DW         = COARSE_W + 9;
   localparam int CMAX       = (1 << COARSE_W) - 1;

   logic       CLK     = 1'b0;
   logic       RSTn    = 1'b0;
   logic       ENABLE  = 1'b0;
   logic       CountOn = 1'b0;
   logic [3:0] Z       = 4'd0;
   logic       FIFO_FULL;
   logic [7:0] DROP_CNT;
   logic       BUSY;

   tdc_hit_readout_if #(.DW(DW)) bus ();

   tdc_hit_readout #(.COARSE_W(COARSE_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .CLK(CLK), .RSTn(RSTn), .ENABLE(ENABLE), .CountOn(CountOn), .Z(Z),
      .bus(bus), .FIFO_FULL(FIFO_FULL), .DROP_CNT(DROP_CNT), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   logic [DW-1:0] expQ [$];
   int            errors     = 0;
   int            checks     = 0;
   int            modelDrops = 0;
   bit            randReady  = 1'b0;
   logic          prevHold   = 1'b0;
   logic [DW-1:0] prevData   = '0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference word straight from the measurement rules
   function automatic logic [DW-1:0] expWord(input int n, input logic [3:0] zs, input logic [3:0] ze);
      int   c;
      logic o;
      c = (n > CMAX) ? CMAX : n;
      o = (n > CMAX);
      return {o, c[COARSE_W-1:0], zs, ze};
   endfunction

   always @(negedge CLK) begin
      if (RSTn) begin
         if (prevHold && bus.DATA_VALID) checkOutput("hold_stable", 32'(bus.DATA_OUT), 32'(prevData));
         if (bus.DATA_VALID && bus.DATA_READY) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_word: got %0h expected none", bus.DATA_OUT);
            end else begin
               checkOutput("word", 32'(bus.DATA_OUT), 32'(expQ.pop_front()));
            end
         end
         prevHold <= bus.DATA_VALID && !bus.DATA_READY;
         prevData <= bus.DATA_OUT;
      end else begin
         prevHold <= 1'b0;
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
      if (randReady) bus.DATA_READY = ($urandom_range(0, 9) < 7);
   endtask

   // Window of n high cycles; returns at the start of the cycle after the fall cycle
   task automatic applyStimulus(input int n, input logic [3:0] zs, input logic [3:0] ze,
                                input bit enRise, input bit enAfter, input bit forceAccept);
      if (enRise) begin
         if (!forceAccept && expQ.size() >= FIFO_DEPTH) begin
            if (modelDrops < 255) modelDrops++;
         end else begin
            expQ.push_back(expWord(n, zs, ze));
         end
      end
      CountOn = 1'b1;
      Z       = zs;
      ENABLE  = enRise;
      tick();
      #3 checkOutput("busy_run", 32'(BUSY), 32'(enRise));
      ENABLE = enAfter;
      for (int i = 1; i < n; i++) begin
         Z = 4'($urandom);
         tick();
      end
      CountOn = 1'b0;
      Z       = ze;
      tick();
      Z = 4'($urandom);
   endtask

   task automatic drain();
      randReady      = 1'b0;
      bus.DATA_READY = 1'b1;
      for (int i = 0; i < 400 && expQ.size() != 0; i++) tick();
      checkOutput("drain_done", 32'(expQ.size()), 32'd0);
      tick();
      tick();
      @(negedge CLK);
      checkOutput("drain_idle_valid", 32'(bus.DATA_VALID), 32'd0);
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus.DATA_READY = 1'b0;
      #12;
      checkOutput("reset_valid", 32'(bus.DATA_VALID), 32'd0);
      checkOutput("reset_data",  32'(bus.DATA_OUT),   32'd0);
      checkOutput("reset_busy",  32'(BUSY),           32'd0);
      checkOutput("reset_full",  32'(FIFO_FULL),      32'd0);
      checkOutput("reset_drop",  32'(DROP_CNT),       32'd0);
      tick();
      RSTn = 1'b1;
      tick();
      tick();

      $display("[TB] nominal pulse");
      bus.DATA_READY = 1'b1;
      applyStimulus(45, 4'd3, 4'd9, 1'b1, 1'b1, 1'b0);
      @(negedge CLK);
      checkOutput("nom_valid_fall_plus1", 32'(bus.DATA_VALID), 32'd0);
      checkOutput("nom_busy_after",       32'(BUSY),           32'd0);
      tick();
      @(negedge CLK);
      checkOutput("nom_valid_fall_plus2", 32'(bus.DATA_VALID), 32'd1);
      tick();
      drain();

      $display("[TB] saturation");
      applyStimulus(300, 4'd5, 4'd12, 1'b1, 1'b1, 1'b0);
      applyStimulus(255, 4'd6, 4'd1,  1'b1, 1'b1, 1'b0);
      applyStimulus(256, 4'd7, 4'd2,  1'b1, 1'b1, 1'b0);
      drain();

      $display("[TB] backpressure");
      bus.DATA_READY = 1'b0;
      for (int i = 0; i < 10; i++) applyStimulus(2, 4'(i), 4'(15 - i), 1'b1, 1'b1, 1'b0);
      tick();
      @(negedge CLK);
      checkOutput("bp_full",  32'(FIFO_FULL), 32'd1);
      checkOutput("bp_drops", 32'(DROP_CNT),  32'(modelDrops));
      tick();
      drain();

      $display("[TB] push and pop on full");
      bus.DATA_READY = 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++)
         applyStimulus($urandom_range(1, 6), 4'($urandom), 4'($urandom), 1'b1, 1'b1, 1'b0);
      tick();
      @(negedge CLK);
      checkOutput("pp_full_before", 32'(FIFO_FULL), 32'd1);
      tick();
      applyStimulus(3, 4'd7, 4'd8, 1'b1, 1'b1, 1'b1);
      bus.DATA_READY = 1'b1;
      tick();
      bus.DATA_READY = 1'b0;
      @(negedge CLK);
      checkOutput("pp_full_after",  32'(FIFO_FULL), 32'd1);
      checkOutput("pp_drops_after", 32'(DROP_CNT),  32'(modelDrops));
      tick();
      drain();

      $display("[TB] enable gating");
      applyStimulus(10, 4'd1, 4'd2, 1'b0, 1'b1, 1'b0);
      tick();
      applyStimulus(10, 4'd4, 4'd6, 1'b1, 1'b0, 1'b0);
      drain();

      $display("[TB] reset mid-run");
      bus.DATA_READY = 1'b0;
      applyStimulus(4, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0);
      tick();
      tick();
      CountOn = 1'b1;
      Z       = 4'd5;
      ENABLE  = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      #5 RSTn = 1'b0;
      expQ.delete();
      modelDrops = 0;
      #2;
      checkOutput("mid_reset_valid", 32'(bus.DATA_VALID), 32'd0);
      checkOutput("mid_reset_data",  32'(bus.DATA_OUT),   32'd0);
      checkOutput("mid_reset_busy",  32'(BUSY),           32'd0);
      checkOutput("mid_reset_full",  32'(FIFO_FULL),      32'd0);
      checkOutput("mid_reset_drop",  32'(DROP_CNT),       32'd0);
      #1 RSTn = 1'b1;
      tick();
      for (int i = 0; i < 11; i++) tick();
      #3 checkOutput("post_reset_no_rise", 32'(BUSY), 32'd0);
      CountOn = 1'b0;
      tick();
      tick();
      @(negedge CLK);
      checkOutput("post_reset_no_word", 32'(bus.DATA_VALID), 32'd0);
      tick();
      bus.DATA_READY = 1'b1;
      applyStimulus(5, 4'd10, 4'd11, 1'b1, 1'b1, 1'b0);
      drain();

      $display("[TB] random traffic");
      randReady = 1'b1;
      for (int k = 0; k < 40; k++) begin
         int waitCnt;
         waitCnt = 0;
         while (expQ.size() > FIFO_DEPTH - 2 && waitCnt < 200) begin
            tick();
            waitCnt++;
         end
         checkOutput("rand_space", 32'(expQ.size() <= FIFO_DEPTH - 2), 32'd1);
         applyStimulus($urandom_range(1, 40), 4'($urandom), 4'($urandom),
                       ($urandom_range(0, 4) != 0), 1'($urandom), 1'b0);
         for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
      end
      drain();
      @(negedge CLK);
      checkOutput("final_drops", 32'(DROP_CNT), 32'(modelDrops));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
